// File: rtl/spi_debug_pkg.sv
// Shared definitions for the debugger SPI command controller: opcode values,
// FSM state encoding and the default status bytes returned to the host.
package spi_debug_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ECHO  = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_WRITE = 8'h03;
  localparam logic [7:0] OP_BURST = 8'h04;

  localparam logic [7:0] STATUS_ACK_DEFAULT = 8'h5A;
  localparam logic [7:0] STATUS_ERR_DEFAULT = 8'hEE;
  localparam logic [7:0] TX_FILLER          = 8'h00;

  // S_CSUM is only reachable when write checksums are enabled
  typedef enum logic [2:0] {
    S_OPCODE = 3'd0,
    S_ECHO   = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_COUNT  = 3'd4,
    S_BURST  = 3'd5,
    S_CSUM   = 3'd6
  } state_e;

  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op <= OP_BURST);
  endfunction

endpackage

// File: rtl/spi_debug_command_controller_cs_sync.sv
// Chip-select synchroniser: brings the raw SPI cs_n into the FPGA clock
// domain through two flops and flags its rising edge (end of an SPI frame).
// Flops reset to 1 so an idle-high cs_n never produces a spurious edge.
module spi_cs_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_cs_n,
  output logic o_cs_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // shift the raw chip select down the synchroniser chain
  always_comb begin
    sync1_d = i_cs_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // synchroniser and edge-history flops
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign o_cs_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/spi_debug_command_controller.sv
// Debugger SPI command sequencer. Decodes opcode/address/count/data frames
// from the SPI peripheral rx port, drives the debug register bus and loads
// exactly one tx byte per received byte.
// Optional build macro SPI_CMD_CHECKSUM_EN: WRITE frames carry a 4th
// checksum byte (OP_WRITE ^ addr ^ data) that must match before committing.
module spi_debug_command_controller
  import spi_debug_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          MAX_BURST  = 255,
  parameter logic [7:0]  STATUS_ACK = STATUS_ACK_DEFAULT,
  parameter logic [7:0]  STATUS_ERR = STATUS_ERR_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_spi_cs_n,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_reg_wr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_rd,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy,
  output logic              o_error
);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        remaining_q, remaining_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              reg_rd_q, reg_rd_d;
  logic              reg_wr_q, reg_wr_d;
  logic              rd_cap_q, rd_cap_d;
  logic              burst_rd_q, burst_rd_d;
  logic              burst_cap_q, burst_cap_d;
  logic              error_q, error_d;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic       cs_rise;
  logic [7:0] count_clamped;

  spi_cs_sync u_cs_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_cs_n    (i_spi_cs_n),
    .o_cs_rise (cs_rise)
  );

  assign count_clamped = (32'(i_rx_byte) > MAX_BURST) ? 8'(MAX_BURST) : i_rx_byte;

  // state register plus all datapath flops
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_OPCODE;
      op_q        <= 8'h00;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      remaining_q <= 8'h00;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      rd_cap_q    <= 1'b0;
      burst_rd_q  <= 1'b0;
      burst_cap_q <= 1'b0;
      error_q     <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      remaining_q <= remaining_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      rd_cap_q    <= rd_cap_d;
      burst_rd_q  <= burst_rd_d;
      burst_cap_q <= burst_cap_d;
      error_q     <= error_d;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // next-state: frame decode on each rx byte; a cs_n rise aborts to S_OPCODE
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_OPCODE;
    end else if (i_rx_dv) begin
      case (state_q)
        S_OPCODE: begin
          case (i_rx_byte)
            OP_ECHO:                     state_d = S_ECHO;
            OP_READ, OP_WRITE, OP_BURST: state_d = S_ADDR;
            default:                     state_d = S_OPCODE;
          endcase
        end
        S_ECHO:  state_d = S_OPCODE;
        S_ADDR: begin
          if (op_q == OP_WRITE)      state_d = S_WDATA;
          else if (op_q == OP_BURST) state_d = S_COUNT;
          else                       state_d = S_OPCODE;
        end
`ifdef SPI_CMD_CHECKSUM_EN
        S_WDATA: state_d = S_CSUM;
        S_CSUM:  state_d = S_OPCODE;
`else
        S_WDATA: state_d = S_OPCODE;
`endif
        S_COUNT: state_d = (i_rx_byte == 8'h00) ? S_OPCODE : S_BURST;
        S_BURST: state_d = (remaining_q == 8'h00) ? S_OPCODE : S_BURST;
        default: state_d = S_OPCODE;
      endcase
    end
  end

  // outputs/datapath: tx byte selection, register strobes and read-data return
  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    remaining_d = remaining_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    rd_cap_d    = reg_rd_q;
    burst_rd_d  = 1'b0;
    burst_cap_d = burst_rd_q;
    error_d     = error_q;
`ifdef SPI_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (cs_rise) begin
      rd_cap_d    = 1'b0;
      burst_cap_d = 1'b0;
      error_d     = 1'b0;
    end else begin
      if (rd_cap_q) begin
        tx_dv_d   = 1'b1;
        tx_byte_d = i_reg_rdata;
        if (burst_cap_q) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      if (i_rx_dv) begin
        case (state_q)
          S_OPCODE: begin
            op_d    = i_rx_byte;
            tx_dv_d = 1'b1;
            if (is_known_opcode(i_rx_byte)) begin
              tx_byte_d = STATUS_ACK;
            end else begin
              tx_byte_d = STATUS_ERR;
              error_d   = 1'b1;
            end
          end
          S_ECHO: begin
            tx_dv_d   = 1'b1;
            tx_byte_d = i_rx_byte;
          end
          S_ADDR: begin
            addr_d = ADDR_W'(i_rx_byte);
`ifdef SPI_CMD_CHECKSUM_EN
            csum_d = OP_WRITE ^ i_rx_byte;
`endif
            if (op_q == OP_READ) begin
              reg_rd_d = 1'b1;
            end else begin
              tx_dv_d   = 1'b1;
              tx_byte_d = TX_FILLER;
            end
          end
          S_WDATA: begin
            wdata_d = i_rx_byte;
            tx_dv_d = 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
            csum_d    = csum_q ^ i_rx_byte;
            tx_byte_d = TX_FILLER;
`else
            reg_wr_d  = 1'b1;
            tx_byte_d = STATUS_ACK;
`endif
          end
`ifdef SPI_CMD_CHECKSUM_EN
          S_CSUM: begin
            tx_dv_d = 1'b1;
            if (i_rx_byte == csum_q) begin
              reg_wr_d  = 1'b1;
              tx_byte_d = STATUS_ACK;
            end else begin
              tx_byte_d = STATUS_ERR;
              error_d   = 1'b1;
            end
          end
`endif
          S_COUNT: begin
            if (i_rx_byte == 8'h00) begin
              tx_dv_d   = 1'b1;
              tx_byte_d = TX_FILLER;
            end else begin
              reg_rd_d    = 1'b1;
              burst_rd_d  = 1'b1;
              remaining_d = count_clamped - 8'd1;
            end
          end
          S_BURST: begin
            if (remaining_q != 8'h00) begin
              reg_rd_d    = 1'b1;
              burst_rd_d  = 1'b1;
              remaining_d = remaining_q - 8'd1;
            end else begin
              tx_dv_d   = 1'b1;
              tx_byte_d = TX_FILLER;
            end
          end
          default: begin
            tx_dv_d   = 1'b1;
            tx_byte_d = TX_FILLER;
          end
        endcase
      end
    end
  end

  assign o_tx_dv     = tx_dv_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wr    = reg_wr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_rd    = reg_rd_q;
  assign o_busy      = (state_q != S_OPCODE);
  assign o_error     = error_q;

endmodule

// File: tb/tb_spi_debug_command_controller.sv
// Scoreboard bench for spi_debug_command_controller. Expected tx bytes and
// register-bus events are queued as stimulus is driven and popped by a
// monitor as the DUT produces them. Honours SPI_CMD_CHECKSUM_EN.
module tb_spi_debug_command_controller;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } regEvent_t;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_spi_cs_n;
  logic [7:0] o_reg_addr;
  logic       o_reg_wr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_rd;
  logic [7:0] i_reg_rdata = 8'h00;
  logic       o_busy;
  logic       o_error;

  int testsRun    = 0;
  int testsFailed = 0;
  bit rdFixed     = 1'b0;

  logic [7:0] txExpQ[$];
  regEvent_t  regExpQ[$];
  logic [7:0] monExp;
  regEvent_t  monEvt;

  spi_debug_command_controller dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rx_dv     (i_rx_dv),
    .i_rx_byte   (i_rx_byte),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_spi_cs_n  (i_spi_cs_n),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wr    (o_reg_wr),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_rd    (o_reg_rd),
    .i_reg_rdata (i_reg_rdata),
    .o_busy      (o_busy),
    .o_error     (o_error)
  );

  // free-running 100 MHz clock
  always #5 i_clk = ~i_clk;

  // register file model: read data is either a fixed pattern or the address, one cycle after rd
  always @(posedge i_clk) begin
    if (o_reg_rd) i_reg_rdata <= rdFixed ? 8'hC3 : o_reg_addr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // monitor: pop the scoreboard whenever the DUT emits a tx byte or a register strobe
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_tx_dv) begin
        if (txExpQ.size() == 0) begin
          checkOutput("tx_unexpected", 32'(o_tx_byte) | 32'h100, 32'h0);
        end else begin
          monExp = txExpQ.pop_front();
          checkOutput("tx_byte", 32'(o_tx_byte), 32'(monExp));
        end
      end
      if (o_reg_rd || o_reg_wr) begin
        if (regExpQ.size() == 0) begin
          checkOutput("reg_unexpected", {30'b0, o_reg_wr, o_reg_rd}, 32'h0);
        end else begin
          monEvt = regExpQ.pop_front();
          checkOutput("reg_kind_wr", 32'(o_reg_wr), 32'(monEvt.wr));
          checkOutput("reg_kind_rd", 32'(o_reg_rd), 32'(!monEvt.wr));
          checkOutput("reg_addr", 32'(o_reg_addr), 32'(monEvt.addr));
          if (monEvt.wr) checkOutput("reg_wdata", 32'(o_reg_wdata), 32'(monEvt.data));
        end
      end
    end
  end

  function automatic void expectRead(input logic [7:0] addr);
    regEvent_t e;
    e.wr = 1'b0; e.addr = addr; e.data = 8'h00;
    regExpQ.push_back(e);
  endfunction

  function automatic void expectWrite(input logic [7:0] addr, input logic [7:0] data);
    regEvent_t e;
    e.wr = 1'b1; e.addr = addr; e.data = data;
    regExpQ.push_back(e);
  endfunction

  // one rx byte; its tx response must arrive within 3 cycles
  task automatic applyStimulus(input logic [7:0] rxByte, input logic [7:0] expTx);
    txExpQ.push_back(expTx);
    @(posedge i_clk); #1;
    i_rx_dv   = 1'b1;
    i_rx_byte = rxByte;
    @(posedge i_clk); #1;
    i_rx_dv   = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("tx_latency", 32'(txExpQ.size()), 32'h0);
    repeat (4) @(posedge i_clk);
  endtask

  task automatic pulseCs();
    @(posedge i_clk); #1;
    i_spi_cs_n = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    checkOutput("abort_busy", 32'(o_busy), 32'h0);
    checkOutput("abort_error", 32'(o_error), 32'h0);
    i_spi_cs_n = 1'b0;
    repeat (4) @(posedge i_clk);
  endtask

  // cs_n rise timed so the synchronised edge lands in the same cycle as an rx byte
  task automatic applyAbortWithByte(input logic [7:0] rxByte);
    @(posedge i_clk); #1;
    i_spi_cs_n = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rx_dv   = 1'b1;
    i_rx_byte = rxByte;
    @(posedge i_clk); #1;
    i_rx_dv   = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("coincident_busy", 32'(o_busy), 32'h0);
    checkOutput("coincident_no_tx", 32'(txExpQ.size()), 32'h0);
    i_spi_cs_n = 1'b0;
    repeat (4) @(posedge i_clk);
  endtask

  // watchdog so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  // main sequence
  initial begin
    i_reset_n  = 1'b0;
    i_rx_dv    = 1'b0;
    i_rx_byte  = 8'h00;
    i_spi_cs_n = 1'b1;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_tx_dv",   32'(o_tx_dv),     32'h0);
    checkOutput("rst_tx_byte", 32'(o_tx_byte),   32'h0);
    checkOutput("rst_reg_rd",  32'(o_reg_rd),    32'h0);
    checkOutput("rst_reg_wr",  32'(o_reg_wr),    32'h0);
    checkOutput("rst_addr",    32'(o_reg_addr),  32'h0);
    checkOutput("rst_wdata",   32'(o_reg_wdata), 32'h0);
    checkOutput("rst_busy",    32'(o_busy),      32'h0);
    checkOutput("rst_error",   32'(o_error),     32'h0);
    @(posedge i_clk); #1;
    i_reset_n  = 1'b1;
    i_spi_cs_n = 1'b0;
    repeat (4) @(posedge i_clk);

    // NOP acks and stays idle
    applyStimulus(8'h00, 8'h5A);
    checkOutput("nop_busy", 32'(o_busy), 32'h0);

    // ECHO
    applyStimulus(8'h01, 8'h5A);
    checkOutput("echo_busy", 32'(o_busy), 32'h1);
    applyStimulus(8'hA5, 8'hA5);

    // READ with fixed read data
    rdFixed = 1'b1;
    applyStimulus(8'h02, 8'h5A);
    expectRead(8'h10);
    applyStimulus(8'h10, 8'hC3);
    rdFixed = 1'b0;
    checkOutput("read_busy", 32'(o_busy), 32'h0);

    // WRITE
    applyStimulus(8'h03, 8'h5A);
    applyStimulus(8'h20, 8'h00);
`ifdef SPI_CMD_CHECKSUM_EN
    applyStimulus(8'h7E, 8'h00);
    expectWrite(8'h20, 8'h7E);
    applyStimulus(8'h5D, 8'h5A);
    checkOutput("csum_ok_error", 32'(o_error), 32'h0);
    applyStimulus(8'h03, 8'h5A);
    applyStimulus(8'h20, 8'h00);
    applyStimulus(8'h7E, 8'h00);
    applyStimulus(8'h00, 8'hEE);
    checkOutput("csum_bad_error", 32'(o_error), 32'h1);
    pulseCs();
`else
    expectWrite(8'h20, 8'h7E);
    applyStimulus(8'h7E, 8'h5A);
`endif
    checkOutput("write_busy", 32'(o_busy), 32'h0);

    // BURST of 3 across the address wrap, read data = address
    applyStimulus(8'h04, 8'h5A);
    applyStimulus(8'hFE, 8'h00);
    expectRead(8'hFE);
    applyStimulus(8'h03, 8'hFE);
    expectRead(8'hFF);
    applyStimulus(8'h55, 8'hFF);
    expectRead(8'h00);
    applyStimulus(8'h66, 8'h00);
    checkOutput("burst_busy_mid", 32'(o_busy), 32'h1);
    applyStimulus(8'h77, 8'h00);
    checkOutput("burst_busy_end", 32'(o_busy), 32'h0);
    checkOutput("burst_end_addr", 32'(o_reg_addr), 32'h01);

    // BURST count 0 and count 1
    applyStimulus(8'h04, 8'h5A);
    applyStimulus(8'h40, 8'h00);
    applyStimulus(8'h00, 8'h00);
    checkOutput("burst0_busy", 32'(o_busy), 32'h0);
    applyStimulus(8'h04, 8'h5A);
    applyStimulus(8'h80, 8'h00);
    expectRead(8'h80);
    applyStimulus(8'h01, 8'h80);
    applyStimulus(8'h99, 8'h00);
    checkOutput("burst1_busy", 32'(o_busy), 32'h0);

    // partial WRITE aborted by cs_n rise, then a fresh opcode
    applyStimulus(8'h03, 8'h5A);
    applyStimulus(8'h20, 8'h00);
    pulseCs();
    applyStimulus(8'h02, 8'h5A);
    checkOutput("after_abort_busy", 32'(o_busy), 32'h1);
    expectRead(8'h30);
    applyStimulus(8'h30, 8'h30);

    // unknown opcode sets a sticky error cleared by cs_n rise
    applyStimulus(8'h7F, 8'hEE);
    checkOutput("bad_op_error", 32'(o_error), 32'h1);
    applyStimulus(8'h00, 8'h5A);
    checkOutput("error_sticky", 32'(o_error), 32'h1);
    pulseCs();

    // abort coincident with an rx byte discards it
    applyStimulus(8'h01, 8'h5A);
    applyAbortWithByte(8'h55);

    // async reset mid-frame
    applyStimulus(8'h03, 8'h5A);
    applyStimulus(8'h20, 8'h00);
    @(posedge i_clk); #3;
    i_reset_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(o_busy), 32'h0);
    checkOutput("async_rst_addr", 32'(o_reg_addr), 32'h0);
    repeat (3) @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    repeat (4) @(posedge i_clk);
    applyStimulus(8'h00, 8'h5A);

    repeat (10) @(posedge i_clk);
    #1;
    checkOutput("tx_drain", 32'(txExpQ.size()), 32'h0);
    checkOutput("reg_drain", 32'(regExpQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
